// File: rtl/mips_instr_encoder.sv
// ----------------------------------------------------------------------------
// Module: mips_instr_encoder
//
// Purpose:
//   Packs an instruction class plus its operand fields into a 32-bit MIPS word.
//   The opcode and funct codes match the ones the main-pipeline control decoder
//   recognises. Encoded words are queued in a small FIFO and streamed out with
//   a valid/ready handshake. Each word carries the instruction-memory byte
//   address it should be loaded at.
//
// Parameters:
//   DEPTH      FIFO entries (power of two, >= 2)
//   BASE_ADDR  byte address of the first word emitted after reset or flush
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   flush      synchronous clear of FIFO and address counter (beats push/pop)
//   in_valid   operand fields valid
//   in_ready   encoder can accept a word (FIFO not full)
//   op_sel     instruction class:
//                0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 JR, 6 LW, 7 SW,
//                8 J, 9 JAL, 10 BEQ, 11 BNE, 12 ADDI, 13 SLTI
//                14/15 are illegal
//   rs,rt,rd   register fields
//   imm        immediate / branch offset
//   target     jump target (word index)
//   out_valid  FIFO head valid
//   out_ready  consumer takes the head word
//   out_data   encoded word at the FIFO head (0 while empty)
//   out_addr   byte address of out_data
//   err_cnt    saturating count of accepted illegal op_sel values
// ----------------------------------------------------------------------------
module mips_instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op_sel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [31:0] out_addr,
    output logic [7:0]  err_cnt
);

    localparam int AW = $clog2(DEPTH);

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    logic [31:0] r_mem [DEPTH];
    logic [AW:0] r_wrPtr;
    logic [AW:0] r_rdPtr;
    logic [31:0] r_addr;
    logic [7:0]  r_errCnt;

    logic [31:0] w_word;
    logic        w_legal;
    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pushLegal;
    logic        w_pushIllegal;
    logic        w_pop;

    // Instruction encoder. Each class lays out the fields the decoder expects.
    // JR drops rt/rd entirely so a stray operand cannot corrupt the word.
    always_comb begin
        w_word  = '0;
        w_legal = 1'b1;
        case (op_sel)
            4'd0:  w_word = {OP_RTYPE, rs, rt, rd, 5'b0, FN_ADD};
            4'd1:  w_word = {OP_RTYPE, rs, rt, rd, 5'b0, FN_SUB};
            4'd2:  w_word = {OP_RTYPE, rs, rt, rd, 5'b0, FN_AND};
            4'd3:  w_word = {OP_RTYPE, rs, rt, rd, 5'b0, FN_OR};
            4'd4:  w_word = {OP_RTYPE, rs, rt, rd, 5'b0, FN_SLT};
            4'd5:  w_word = {OP_RTYPE, rs, 15'b0, FN_JR};
            4'd6:  w_word = {OP_LW,   rs, rt, imm};
            4'd7:  w_word = {OP_SW,   rs, rt, imm};
            4'd8:  w_word = {OP_J,    target};
            4'd9:  w_word = {OP_JAL,  target};
            4'd10: w_word = {OP_BEQ,  rs, rt, imm};
            4'd11: w_word = {OP_BNE,  rs, rt, imm};
            4'd12: w_word = {OP_ADDI, rs, rt, imm};
            4'd13: w_word = {OP_SLTI, rs, rt, imm};
            default: w_legal = 1'b0;
        endcase
    end

    // The pointers carry one extra wrap bit. Equal pointers mean empty.
    // Pointers that differ only in the wrap bit mean full.
    assign w_empty = (r_wrPtr == r_rdPtr);
    assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                     (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;

    // flush wins over both handshakes, so neither side may move on a flush edge.
    assign w_push        = in_valid && !w_full && !flush;
    assign w_pushLegal   = w_push && w_legal;
    assign w_pushIllegal = w_push && !w_legal;
    assign w_pop         = !w_empty && out_ready && !flush;

    // Storage needs no reset: an entry is only observable between push and pop.
    always_ff @(posedge clk) begin
        if (w_pushLegal) begin
            r_mem[r_wrPtr[AW-1:0]] <= w_word;
        end
    end

    // Read/write pointers. An illegal push is consumed from the producer but
    // never occupies a slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else if (flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_pushLegal) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
        end
    end

    // Byte address of the head word. It advances one word per pop and wraps
    // naturally at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr <= BASE_ADDR;
        end else if (flush) begin
            r_addr <= BASE_ADDR;
        end else if (w_pop) begin
            r_addr <= r_addr + 32'd4;
        end
    end

    // Illegal-op counter. It survives flush and sticks at 255.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_errCnt <= '0;
        end else if (w_pushIllegal && (r_errCnt != 8'hFF)) begin
            r_errCnt <= r_errCnt + 8'd1;
        end
    end

    // Head word is forced to zero while empty so stale entries never leak out.
    assign out_data = w_empty ? 32'h0 : r_mem[r_rdPtr[AW-1:0]];
    assign out_addr = r_addr;
    assign err_cnt  = r_errCnt;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// ----------------------------------------------------------------------------
// Testbench: tb_mips_instr_encoder
//
// Purpose:
//   Self-checking bench for mips_instr_encoder. A queue-based reference model
//   tracks the FIFO contents, the address counter and the error counter. It
//   encodes words from opcode/funct tables using plain arithmetic.
// ----------------------------------------------------------------------------
module tb_mips_instr_encoder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [3:0]  opSel;
    logic [4:0]  rsF;
    logic [4:0]  rtF;
    logic [4:0]  rdF;
    logic [15:0] immF;
    logic [25:0] targetF;
    logic        outValid;
    logic        outReady;
    logic [31:0] outData;
    logic [31:0] outAddr;
    logic [7:0]  errCnt;

    int total = 0;
    int bad   = 0;

    logic [31:0] mq[$];
    logic [31:0] mAddr;
    int          mErr;

    mips_instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .in_valid(inValid),
        .in_ready(inReady),
        .op_sel(opSel),
        .rs(rsF),
        .rt(rtF),
        .rd(rdF),
        .imm(immF),
        .target(targetF),
        .out_valid(outValid),
        .out_ready(outReady),
        .out_data(outData),
        .out_addr(outAddr),
        .err_cnt(errCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoder. Classes: 0 = R-type, 1 = JR, 2 = I-type, 3 = J-type.
    function automatic logic [31:0] refEncode(input int op, input int rs,
                                              input int rt, input int rd,
                                              input int imm, input int tgt);
        int primary [14] = '{0, 0, 0, 0, 0, 0, 35, 43, 2, 3, 4, 5, 8, 10};
        int funct   [14] = '{32, 34, 36, 37, 42, 8, 0, 0, 0, 0, 0, 0, 0, 0};
        int kind    [14] = '{0, 0, 0, 0, 0, 1, 2, 2, 3, 3, 2, 2, 2, 2};
        longint w;
        w = longint'(primary[op]) * 64'd67108864;
        case (kind[op])
            0: w = w + rs * 2097152 + rt * 65536 + rd * 2048 + funct[op];
            1: w = w + rs * 2097152 + funct[op];
            2: w = w + rs * 2097152 + rt * 65536 + imm;
            default: w = w + tgt;
        endcase
        return w[31:0];
    endfunction

    task automatic applyInputs(input logic v, input int op, input int rs,
                               input int rt, input int rd, input int imm,
                               input int tgt, input logic rdy, input logic fl);
        inValid  = v;
        opSel    = op[3:0];
        rsF      = rs[4:0];
        rtF      = rt[4:0];
        rdF      = rd[4:0];
        immF     = imm[15:0];
        targetF  = tgt[25:0];
        outReady = rdy;
        flush    = fl;
    endtask

    // One clock edge. The model decides push/pop from the pre-edge state,
    // applies them, and outputs are then sampled 1ns after the edge.
    task automatic clockStep();
        bit doPush;
        bit doPop;
        doPush = inValid && (mq.size() < DEPTH);
        doPop  = outReady && (mq.size() > 0);
        @(posedge clk);
        if (flush) begin
            mq.delete();
            mAddr = BASE;
        end else begin
            if (doPop) begin
                void'(mq.pop_front());
                mAddr = mAddr + 32'd4;
            end
            if (doPush) begin
                if (opSel <= 4'd13)
                    mq.push_back(refEncode(int'(opSel), int'(rsF), int'(rtF),
                                           int'(rdF), int'(immF), int'(targetF)));
                else if (mErr < 255)
                    mErr++;
            end
        end
        #1;
    endtask

    task automatic modelReset();
        mq.delete();
        mAddr = BASE;
        mErr  = 0;
    endtask

    task automatic test_reset();
        applyInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        modelReset();
        #13;
        total++;
        if (outValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", outValid); end
        total++;
        if (outData !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", outData); end
        total++;
        if (outAddr !== BASE) begin bad++; $display("FAIL reset_addr got=%h want=%h", outAddr, BASE); end
        total++;
        if (errCnt !== 8'd0) begin bad++; $display("FAIL reset_err got=%0d want=0", errCnt); end
        total++;
        if (inReady !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", inReady); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        applyInputs(1, 0, 1, 2, 3, 0, 0, 0, 0);
        clockStep();
        applyInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (outValid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b want=1", outValid); end
        total++;
        if (outData !== 32'h0022_1820) begin bad++; $display("FAIL add_data got=%h want=00221820", outData); end
        total++;
        if (outAddr !== 32'h0) begin bad++; $display("FAIL add_addr got=%h want=0", outAddr); end
        applyInputs(0, 0, 0, 0, 0, 0, 0, 1, 0);
        clockStep();
        applyInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (outValid !== 1'b0) begin bad++; $display("FAIL add_drain got=%b want=0", outValid); end
    endtask

    task automatic test_lw_j();
        // The flush returns the address counter to BASE before this scenario.
        applyInputs(0, 0, 0, 0, 0, 0, 0, 0, 1);
        clockStep();
        applyInputs(1, 6, 4, 5, 0, 16'hFFFC, 0, 0, 0);
        clockStep();
        applyInputs(1, 8, 0, 0, 0, 0, 26'h10, 0, 0);
        clockStep();
        applyInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (outData !== 32'h8C85_FFFC || outAddr !== 32'h0) begin
            bad++; $display("FAIL lw_word got=%h@%h want=8c85fffc@0", outData, outAddr);
        end
        applyInputs(0, 0, 0, 0, 0, 0, 0, 1, 0);
        clockStep();
        total++;
        if (outData !== 32'h0800_0010 || outAddr !== 32'h4) begin
            bad++; $display("FAIL j_word got=%h@%h want=08000010@4", outData, outAddr);
        end
        clockStep();
        applyInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (outValid !== 1'b0) begin bad++; $display("FAIL lw_j_drain got=%b want=0", outValid); end
    endtask

    task automatic test_full();
        logic [31:0] expWord;
        for (int i = 0; i < 4; i++) begin
            applyInputs(1, 12, i + 1, i + 2, 0, 16'h100 + i, 0, 0, 0);
            clockStep();
        end
        total++;
        if (inReady !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", inReady); end
        applyInputs(1, 13, 9, 10, 0, 16'h0555, 0, 0, 0);
        clockStep();
        total++;
        if (inReady !== 1'b0 || outData !== refEncode(12, 1, 2, 0, 16'h100, 0)) begin
            bad++; $display("FAIL full_hold got=%b/%h want=0/%h", inReady, outData,
                            refEncode(12, 1, 2, 0, 16'h100, 0));
        end
        // Pop at a full edge: the fifth word stays pending until the next edge.
        outReady = 1'b1;
        clockStep();
        outReady = 1'b0;
        total++;
        if (inReady !== 1'b1) begin bad++; $display("FAIL full_free got=%b want=1", inReady); end
        clockStep();
        inValid = 1'b0;
        outReady = 1'b1;
        for (int i = 1; i < 5; i++) begin
            expWord = (i < 4) ? refEncode(12, i + 1, i + 2, 0, 16'h100 + i, 0)
                              : refEncode(13, 9, 10, 0, 16'h0555, 0);
            total++;
            if (outData !== expWord) begin
                bad++; $display("FAIL full_order%0d got=%h want=%h", i, outData, expWord);
            end
            clockStep();
        end
        outReady = 1'b0;
        total++;
        if (outValid !== 1'b0) begin bad++; $display("FAIL full_drain got=%b want=0", outValid); end
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 300; i++) begin
            applyInputs(1, 15 - (i % 2), i % 32, 0, 0, 0, 0, 0, 0);
            clockStep();
            if (i == 253) begin
                total++;
                if (errCnt !== 8'd254) begin bad++; $display("FAIL err_254 got=%0d want=254", errCnt); end
            end
        end
        applyInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (errCnt !== 8'd255 || mErr != 255) begin
            bad++; $display("FAIL err_sat got=%0d want=255", errCnt);
        end
        total++;
        if (outValid !== 1'b0 || inReady !== 1'b1) begin
            bad++; $display("FAIL err_empty got=%b/%b want=0/1", outValid, inReady);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) begin
            applyInputs(1, i, i, i + 1, i + 2, 0, 0, 0, 0);
            clockStep();
        end
        applyInputs(0, 0, 0, 0, 0, 0, 0, 1, 0);
        clockStep();
        clockStep();
        total++;
        if (outAddr !== mAddr) begin bad++; $display("FAIL flush_pre_addr got=%h want=%h", outAddr, mAddr); end
        applyInputs(1, 6, 3, 3, 0, 16'h1234, 0, 1, 1);
        clockStep();
        applyInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (outValid !== 1'b0 || outAddr !== BASE) begin
            bad++; $display("FAIL flush_state got=%b@%h want=0@%h", outValid, outAddr, BASE);
        end
        total++;
        if (errCnt !== 8'd255) begin bad++; $display("FAIL flush_err got=%0d want=255", errCnt); end
        clockStep();
        total++;
        if (outValid !== 1'b0) begin bad++; $display("FAIL flush_drop got=%b want=0", outValid); end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 6; i++) begin
            applyInputs(1, i, i, i, i, i, 0, i % 2, 0);
            clockStep();
        end
        #2;
        rst = 1'b0;
        modelReset();
        #1;
        total++;
        if (outValid !== 1'b0 || outData !== 32'h0 || outAddr !== BASE ||
            errCnt !== 8'd0 || inReady !== 1'b1) begin
            bad++; $display("FAIL midreset got=%b/%h/%h/%0d/%b want=0/0/%h/0/1",
                            outValid, outData, outAddr, errCnt, inReady, BASE);
        end
        applyInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        applyInputs(1, 5, 31, 7, 9, 0, 0, 0, 0);
        clockStep();
        applyInputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        total++;
        if (outData !== 32'h03E0_0008 || outAddr !== BASE) begin
            bad++; $display("FAIL jr_word got=%h@%h want=03e00008@%h", outData, outAddr, BASE);
        end
    endtask

    task automatic test_random();
        logic [31:0] expData;
        for (int i = 0; i < 400; i++) begin
            applyInputs(($urandom % 4) != 0, $urandom_range(0, 15),
                        $urandom % 32, $urandom % 32, $urandom % 32,
                        $urandom % 65536, $urandom % 67108864,
                        ($urandom % 3) != 0, ($urandom % 40) == 0);
            clockStep();
            expData = (mq.size() > 0) ? mq[0] : 32'h0;
            total++;
            if (outValid !== (mq.size() > 0)) begin
                bad++; $display("FAIL rnd_valid[%0d] got=%b want=%b", i, outValid, mq.size() > 0);
            end
            total++;
            if (outData !== expData) begin
                bad++; $display("FAIL rnd_data[%0d] got=%h want=%h", i, outData, expData);
            end
            total++;
            if (outAddr !== mAddr) begin
                bad++; $display("FAIL rnd_addr[%0d] got=%h want=%h", i, outAddr, mAddr);
            end
            total++;
            if (inReady !== (mq.size() < DEPTH)) begin
                bad++; $display("FAIL rnd_ready[%0d] got=%b want=%b", i, inReady, mq.size() < DEPTH);
            end
            total++;
            if (int'(errCnt) != mErr) begin
                bad++; $display("FAIL rnd_err[%0d] got=%0d want=%0d", i, errCnt, mErr);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        modelReset();
        test_reset();
        test_add();
        test_lw_j();
        test_full();
        test_illegal();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
